// File: rtl/hit_scheduler.sv
// hit_scheduler: turns per-step instrument hit patterns into a serial stream
// of note triggers for a single shared synth, one voice at a time, using a
// start/busy handshake and round-robin priority across steps.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | nothing in flight; issue when hits are pending and synth idle
// ISSUE     | one-cycle synth_start pulse, selected voice latched
// WAIT_ACK  | waiting for synth_busy to rise; voice dropped on timeout
// WAIT_DONE | synth playing; wait for synth_busy to fall
module hit_scheduler #(
  parameter int ACK_TIMEOUT = 16,
  parameter int TO_W        = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       play,
  input  logic [3:0] timing,
  input  logic [7:0] pattern1,
  input  logic [7:0] pattern2,
  input  logic [7:0] pattern3,
  input  logic [7:0] pattern4,
  input  logic [3:0] mute,
  input  logic       synth_busy,
  output logic       synth_start,
  output logic [1:0] synth_voice,
  output logic [3:0] pending,
  output logic       overrun
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE} state_t;

  state_t          state_q, state_d;
  logic [3:0]      prev_timing_q;
  logic [3:0]      pending_q, pending_d;
  logic [1:0]      last_voice_q, last_voice_d;
  logic [1:0]      voice_q, voice_d;
  logic            overrun_q, overrun_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  logic            step_evt;
  logic [2:0]      step_idx;
  logic [3:0]      hits;
  logic [1:0]      sel;
  logic [1:0]      cand;
  logic            fire;

  // Steps 1..8 map to pattern bits 0..7; 9..15 never qualify as a step.
  assign step_idx = timing[2:0] - 3'd1;
  assign step_evt = play && (timing != 4'd0) && (timing <= 4'd8) &&
                    (timing != prev_timing_q);

  // A voice is only really issued if there is still something to issue and
  // play has not been dropped in the ISSUE cycle itself.
  assign fire = (state_q == ISSUE) && play && (pending_q != 4'b0000);

  // Hit vector for the step being captured, with muted instruments removed.
  always_comb begin
    hits = 4'b0000;
    if (step_evt) begin
      hits[0] = pattern1[step_idx] & ~mute[0];
      hits[1] = pattern2[step_idx] & ~mute[1];
      hits[2] = pattern3[step_idx] & ~mute[2];
      hits[3] = pattern4[step_idx] & ~mute[3];
    end
  end

  // Round-robin pick: nearest set pending bit after last_voice, wrapping.
  always_comb begin
    sel  = 2'd0;
    cand = 2'd0;
    for (int k = 4; k >= 1; k--) begin
      cand = last_voice_q + 2'(k);
      if (pending_q[cand]) sel = cand;
    end
  end

  // Handshake FSM next state plus pending/voice/timeout bookkeeping.
  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    last_voice_d = last_voice_q;
    voice_d      = voice_q;
    to_cnt_d     = to_cnt_q;
    overrun_d    = step_evt && (pending_q != 4'b0000);

    case (state_q)
      IDLE: begin
        if (play && (pending_q != 4'b0000) && !synth_busy) state_d = ISSUE;
      end
      ISSUE: begin
        if (fire) begin
          state_d      = WAIT_ACK;
          voice_d      = sel;
          last_voice_d = sel;
          to_cnt_d     = '0;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_ACK: begin
        if (!play) begin
          state_d = IDLE;
        end else if (synth_busy) begin
          state_d = WAIT_DONE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
          if (to_cnt_d == TO_W'(ACK_TIMEOUT - 1)) state_d = IDLE;
        end
      end
      WAIT_DONE: begin
        // The synth is never cut off, even when play drops.
        if (!synth_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A fresh capture overrides the clear of the voice being issued.
    if (!play) begin
      pending_d = 4'b0000;
    end else if (step_evt) begin
      pending_d = hits;
    end else if (fire) begin
      pending_d = pending_q & ~(4'b0001 << sel);
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      prev_timing_q <= 4'd0;
      pending_q     <= 4'b0000;
      last_voice_q  <= 2'd3;
      voice_q       <= 2'd0;
      overrun_q     <= 1'b0;
      to_cnt_q      <= '0;
    end else begin
      state_q       <= state_d;
      prev_timing_q <= timing;
      pending_q     <= pending_d;
      last_voice_q  <= last_voice_d;
      voice_q       <= voice_d;
      overrun_q     <= overrun_d;
      to_cnt_q      <= to_cnt_d;
    end
  end

  assign synth_start = fire;
  assign synth_voice = fire ? sel : voice_q;
  assign pending     = pending_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_hit_scheduler.sv
// Testbench for hit_scheduler: capture vector table, directed handshake
// sequences and a randomized run against a behavioural reference model.
module tb_hit_scheduler;
  localparam int ACK_TIMEOUT = 16;
  localparam int TO_W        = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       play = 1'b0;
  logic [3:0] timing = 4'd0;
  logic [7:0] pattern1 = 8'h00, pattern2 = 8'h00, pattern3 = 8'h00, pattern4 = 8'h00;
  logic [3:0] mute = 4'b0000;
  logic       synth_busy = 1'b0;
  logic       synth_start;
  logic [1:0] synth_voice;
  logic [3:0] pending;
  logic       overrun;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  hit_scheduler #(.ACK_TIMEOUT(ACK_TIMEOUT), .TO_W(TO_W)) dut (
    .clk(clk), .reset(reset), .play(play), .timing(timing),
    .pattern1(pattern1), .pattern2(pattern2), .pattern3(pattern3), .pattern4(pattern4),
    .mute(mute), .synth_busy(synth_busy), .synth_start(synth_start),
    .synth_voice(synth_voice), .pending(pending), .overrun(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Synth responder: busy rises rs_delay cycles after arming, lasts rs_len cycles.
  int rs_delay = 0;
  int rs_len = 0;
  task automatic resp_drive();
    if (rs_delay > 0) begin rs_delay--; synth_busy = 1'b0; end
    else if (rs_len > 0) begin rs_len--; synth_busy = 1'b1; end
    else synth_busy = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0; play = 1'b0; timing = 4'd0; mute = 4'b0000; synth_busy = 1'b0;
    pattern1 = 8'h00; pattern2 = 8'h00; pattern3 = 8'h00; pattern4 = 8'h00;
    rs_delay = 0; rs_len = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  int st_voice[$];
  int st_pend[$];
  int st_cyc[$];
  int ovr_cnt;

  // Run with the responder, logging each start, its voice and pending a cycle later.
  task automatic run_collect(input int n_want, input int blen, input int budget);
    bit need_p;
    need_p = 1'b0;
    st_voice.delete(); st_pend.delete(); st_cyc.delete(); ovr_cnt = 0;
    for (int c = 0; c < budget; c++) begin
      if (st_voice.size() >= n_want && !need_p) break;
      resp_drive();
      @(negedge clk);
      if (overrun === 1'b1) ovr_cnt++;
      if (need_p) begin st_pend.push_back(int'(pending)); need_p = 1'b0; end
      if (synth_start === 1'b1) begin
        st_voice.push_back(int'(synth_voice));
        st_cyc.push_back(cyc);
        need_p = 1'b1;
        rs_delay = 0;
        rs_len = blen;
      end
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- reference model ----------------
  bit [3:0] m_pend;
  int       m_last, m_prev, m_voice, m_slot, m_t_start;
  bit       m_ovr;

  task automatic model_init();
    m_pend = 4'b0000; m_last = 3; m_prev = 0; m_voice = 0; m_slot = 0; m_t_start = 0; m_ovr = 1'b0;
  endtask

  function automatic bit [3:0] m_hits();
    bit [3:0] h;
    int b;
    h = 4'b0000;
    if (timing >= 1 && timing <= 8) begin
      b = int'(timing) - 1;
      h[0] = pattern1[b] & ~mute[0];
      h[1] = pattern2[b] & ~mute[1];
      h[2] = pattern3[b] & ~mute[2];
      h[3] = pattern4[b] & ~mute[3];
    end
    return h;
  endfunction

  function automatic int m_pick();
    for (int k = 1; k <= 4; k++) begin
      if (m_pend[(m_last + k) % 4]) return (m_last + k) % 4;
    end
    return 0;
  endfunction

  function automatic bit m_fire();
    return (m_slot == 1) && play && (m_pend != 4'b0000);
  endfunction

  // slot: 0 free, 1 start due, 2 awaiting ack, 3 synth playing
  task automatic model_clock();
    bit fire, step;
    int sel, ns;
    bit [3:0] np;
    fire = m_fire();
    sel = m_pick();
    step = play && timing >= 1 && timing <= 8 && int'(timing) != m_prev;
    if (!play) np = 4'b0000;
    else if (step) np = m_hits();
    else if (fire) np = m_pend & ~(4'b0001 << sel);
    else np = m_pend;
    m_ovr = step && (m_pend != 4'b0000);
    ns = m_slot;
    case (m_slot)
      0: if (play && m_pend != 4'b0000 && !synth_busy) ns = 1;
      1: if (fire) begin ns = 2; m_voice = sel; m_last = sel; m_t_start = cyc; end else ns = 0;
      2: if (!play) ns = 0;
         else if (synth_busy) ns = 3;
         else if (cyc - m_t_start + 1 >= ACK_TIMEOUT) ns = 0;
      3: if (!synth_busy) ns = 0;
      default: ns = 0;
    endcase
    m_pend = np;
    m_slot = ns;
    m_prev = int'(timing);
  endtask

  // ---------------- capture vector table ----------------
  typedef struct {
    logic [3:0] t;
    logic [7:0] p1, p2, p3, p4;
    logic [3:0] m;
    logic [3:0] ep;
    logic       eo;
  } vec_t;

  vec_t vt[8];

  initial begin
    int t0, s0;
    bit exp_start;
    int exp_voice;

    vt[0] = '{4'd1, 8'h01, 8'h01, 8'h01, 8'h01, 4'b0000, 4'b1111, 1'b0};
    vt[1] = '{4'd5, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 4'b0101, 4'b1010, 1'b1};
    vt[2] = '{4'd8, 8'h80, 8'h00, 8'h80, 8'h7F, 4'b0000, 4'b0101, 1'b1};
    vt[3] = '{4'd3, 8'h04, 8'h04, 8'h00, 8'h00, 4'b0001, 4'b0010, 1'b1};
    vt[4] = '{4'd9, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 4'b0000, 4'b0010, 1'b0};
    vt[5] = '{4'd2, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000, 4'b0000, 1'b1};
    vt[6] = '{4'd4, 8'h08, 8'h08, 8'h08, 8'h08, 4'b1111, 4'b0000, 1'b0};
    vt[7] = '{4'd7, 8'h40, 8'hBF, 8'h40, 8'h40, 4'b0000, 4'b1101, 1'b0};

    // Reset values
    do_reset();
    @(negedge clk);
    check("rst_start", synth_start, 0);
    check("rst_voice", synth_voice, 0);
    check("rst_pending", pending, 0);
    check("rst_overrun", overrun, 0);
    @(posedge clk); #1;

    // Capture table; synth held busy so nothing is issued
    play = 1'b1; synth_busy = 1'b1;
    foreach (vt[i]) begin
      timing = 4'd0;
      @(posedge clk); #1;
      timing = vt[i].t; pattern1 = vt[i].p1; pattern2 = vt[i].p2;
      pattern3 = vt[i].p3; pattern4 = vt[i].p4; mute = vt[i].m;
      @(posedge clk); @(negedge clk);
      check($sformatf("vec%0d_pending", i), pending, vt[i].ep);
      check($sformatf("vec%0d_overrun", i), overrun, vt[i].eo);
      @(posedge clk); #1;
    end

    // All instruments on step 1, busy 3 cycles per note: voices 0..3 in order
    do_reset();
    pattern1 = 8'h01; pattern2 = 8'h01; pattern3 = 8'h01; pattern4 = 8'h01; play = 1'b1;
    timing = 4'd1; t0 = cyc;
    @(negedge clk); check("a_pend_n", pending, 4'b0000);
    @(posedge clk); #1;
    @(negedge clk); check("a_pend_n1", pending, 4'b1111); check("a_nostart_n1", synth_start, 0);
    @(posedge clk); #1;
    run_collect(4, 3, 80);
    check("a_nstarts", st_voice.size(), 4);
    if (st_cyc.size() > 0) check("a_latency", st_cyc[0] - t0, 2);
    for (int i = 0; i < st_voice.size() && i < 4; i++) begin
      check($sformatf("a_voice%0d", i), st_voice[i], i);
      if (i < st_pend.size()) check($sformatf("a_pend%0d", i), st_pend[i], (4'b1110 << i) & 4'hF);
    end

    // Next step hits instruments 2 and 4: last voice was 3, so voice 1 first
    pattern2 = 8'h03; pattern4 = 8'h03; timing = 4'd2;
    run_collect(2, 3, 60);
    check("b_nstarts", st_voice.size(), 2);
    if (st_voice.size() == 2) begin
      check("b_voice0", st_voice[0], 1);
      check("b_voice1", st_voice[1], 3);
    end
    check("b_overrun", ovr_cnt, 0);

    // Mute 0101 with all patterns FF at step 5: only voices 1 and 3
    do_reset();
    pattern1 = 8'hFF; pattern2 = 8'hFF; pattern3 = 8'hFF; pattern4 = 8'hFF;
    mute = 4'b0101; play = 1'b1; timing = 4'd5;
    run_collect(2, 3, 60);
    check("m_nstarts", st_voice.size(), 2);
    if (st_voice.size() == 2) begin
      check("m_voice0", st_voice[0], 1);
      check("m_voice1", st_voice[1], 3);
    end
    run_collect(99, 3, 20);
    check("m_extra", st_voice.size(), 0);

    // Long busy; step advances mid-note: one overrun, pending reloaded
    do_reset();
    pattern1 = 8'h03; pattern2 = 8'h03; pattern3 = 8'h03; pattern4 = 8'h03;
    play = 1'b1; timing = 4'd1;
    run_collect(1, 40, 10);
    check("o_voice", st_voice.size() > 0 ? st_voice[0] : -1, 0);
    check("o_pend_before", st_pend.size() > 0 ? st_pend[0] : -1, 4'b1110);
    timing = 4'd2;
    run_collect(99, 40, 6);
    check("o_overruns", ovr_cnt, 1);
    check("o_pend_after", pending, 4'b1111);
    check("o_nostart", st_voice.size(), 0);

    // Busy never rises: voice dropped after the ack timeout
    do_reset();
    pattern3 = 8'h01; play = 1'b1; timing = 4'd1;
    run_collect(1, 0, 10);
    s0 = st_cyc.size() > 0 ? st_cyc[0] : 0;
    check("t_voice", st_voice.size() > 0 ? st_voice[0] : -1, 2);
    check("t_pend", st_pend.size() > 0 ? st_pend[0] : -1, 0);
    pattern1 = 8'h02; timing = 4'd2;
    run_collect(1, 0, 40);
    check("t_restart_gap", st_cyc.size() > 0 ? st_cyc[0] - s0 : -1, ACK_TIMEOUT + 1);
    check("t_restart_voice", st_voice.size() > 0 ? st_voice[0] : -1, 0);
    check("t_overrun", ovr_cnt, 0);

    // Play dropped while the synth is playing
    do_reset();
    pattern1 = 8'h03; pattern2 = 8'h03; pattern3 = 8'h03; pattern4 = 8'h03;
    play = 1'b1; timing = 4'd1;
    run_collect(1, 10, 10);
    s0 = st_cyc.size() > 0 ? st_cyc[0] : 0;
    play = 1'b0;
    run_collect(99, 10, 1);
    check("p_pend_cleared", pending, 0);
    run_collect(99, 10, 3);
    check("p_nostart", st_voice.size(), 0);
    check("p_noovr", ovr_cnt, 0);
    play = 1'b1; timing = 4'd2;
    run_collect(1, 10, 30);
    check("p_restart_gap", st_cyc.size() > 0 ? st_cyc[0] - s0 : -1, 13);
    check("p_restart_voice", st_voice.size() > 0 ? st_voice[0] : -1, 1);

    // Asynchronous reset in the middle of the ack wait
    do_reset();
    pattern2 = 8'h01; pattern4 = 8'h01; play = 1'b1; timing = 4'd1;
    run_collect(1, 0, 10);
    check("r_voice_held", synth_voice, 1);
    check("r_pend_before", pending, 4'b1000);
    #2 reset = 1'b0;
    #1;
    check("r_start", synth_start, 0);
    check("r_voice", synth_voice, 0);
    check("r_pending", pending, 0);
    check("r_overrun", overrun, 0);
    #1 reset = 1'b1;
    @(posedge clk); #1;

    // Randomized run against the reference model
    do_reset();
    model_init();
    play = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      if (play) begin
        if ($urandom_range(0, 99) < 3) play = 1'b0;
      end else if ($urandom_range(0, 1) == 0) play = 1'b1;
      if ($urandom_range(0, 7) == 0) timing = 4'($urandom_range(0, 10));
      if ($urandom_range(0, 19) == 0) begin
        pattern1 = 8'($urandom_range(0, 255)); pattern2 = 8'($urandom_range(0, 255));
        pattern3 = 8'($urandom_range(0, 255)); pattern4 = 8'($urandom_range(0, 255));
        mute = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      end
      resp_drive();
      @(negedge clk);
      exp_start = m_fire();
      exp_voice = exp_start ? m_pick() : m_voice;
      check("rnd_start", synth_start, exp_start);
      check("rnd_voice", synth_voice, exp_voice);
      check("rnd_pending", pending, m_pend);
      check("rnd_overrun", overrun, m_ovr);
      if (exp_start) begin
        if ($urandom_range(0, 5) == 0) begin
          rs_delay = 0; rs_len = 0;
        end else begin
          rs_delay = $urandom_range(0, 2); rs_len = $urandom_range(1, 6);
        end
      end
      model_clock();
      @(posedge clk);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
